// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX operand forwarding, load-use interlock and data-memory wait freeze for the 5-stage pipeline
module hazard_forward_ctrl #(
  parameter int REG_W = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] if_id_rs1,
  input  logic [REG_W-1:0] if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic [REG_W-1:0] id_ex_Rs1,
  input  logic [REG_W-1:0] id_ex_Rs2,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_MemRead,
  input  logic [REG_W-1:0] ex_mem_rd,
  input  logic             ex_mem_Regwrite,
  input  logic             ex_mem_MemRead,
  input  logic             ex_mem_MemWrite,
  input  logic [REG_W-1:0] mem_wb_rd,
  input  logic             mem_wb_Regwrite,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall_fd,
  output logic             bubble_ex,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] load_use_events
);
  localparam logic [2:0] LUS = 3'(LOAD_USE_STALLS);
  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  state_t state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, lue_q;
  logic timeout_q, ex_ok, wb_ok, lu_hit, freeze_req, release_mw, fz, sf, bx, lu_evt, to_set;
  assign ex_ok = ex_mem_Regwrite && ex_mem_rd != '0 && !ex_mem_MemRead;
  assign wb_ok = mem_wb_Regwrite && mem_wb_rd != '0;
  assign forwardA = rst ? 2'b00 : (ex_ok && ex_mem_rd == id_ex_Rs1) ? 2'b10 : (wb_ok && mem_wb_rd == id_ex_Rs1) ? 2'b01 : 2'b00;
  assign forwardB = rst ? 2'b00 : (ex_ok && ex_mem_rd == id_ex_Rs2) ? 2'b10 : (wb_ok && mem_wb_rd == id_ex_Rs2) ? 2'b01 : 2'b00;
  assign lu_hit = id_ex_MemRead && id_ex_rd != '0 &&
                  ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) || (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
  assign freeze_req = (ex_mem_MemRead || ex_mem_MemWrite) && !dmem_ready;
  assign release_mw = dmem_ready || wait_cnt_q == TMO;
  always_comb begin
    state_d = state_q;
    lu_cnt_d = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    fz = 1'b0;
    sf = 1'b0;
    bx = 1'b0;
    lu_evt = 1'b0;
    to_set = 1'b0;
    case (state_q)
      RUN: begin
        if (freeze_req) begin
          fz = 1'b1;
          state_d = MEM_WAIT;
          wait_cnt_d = 16'd1;
        end else if (lu_hit) begin
          sf = 1'b1;
          bx = 1'b1;
          lu_evt = 1'b1;
          if (LUS > 3'd1) begin
            state_d = LU_STALL;
            lu_cnt_d = LUS - 3'd1;
          end
        end
      end
      LU_STALL: begin
        // a frozen cycle still uses up one of the remaining bubbles
        lu_cnt_d = lu_cnt_q - 3'd1;
        if (freeze_req) begin
          fz = 1'b1;
          state_d = MEM_WAIT;
          wait_cnt_d = 16'd1;
        end else begin
          sf = 1'b1;
          bx = 1'b1;
          state_d = lu_cnt_q == 3'd1 ? RUN : LU_STALL;
        end
      end
      MEM_WAIT: begin
        fz = !release_mw;
        wait_cnt_d = release_mw ? 16'd0 : wait_cnt_q + 16'd1;
        to_set = release_mw && !dmem_ready;
        state_d = !release_mw ? MEM_WAIT : lu_cnt_q != 3'd0 ? LU_STALL : RUN;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      lu_cnt_q <= '0;
      wait_cnt_q <= '0;
      stall_q <= '0;
      lue_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lu_cnt_q <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      if (to_set) timeout_q <= 1'b1;
      if (perf_clr) begin
        stall_q <= '0;
        lue_q <= '0;
      end else begin
        if ((sf || fz) && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
        if (lu_evt && !(&lue_q)) lue_q <= lue_q + CNT_W'(1);
      end
    end
  end
  assign freeze = !rst && fz;
  assign stall_fd = !rst && (sf || fz);
  assign bubble_ex = !rst && bx;
  assign mem_timeout = timeout_q;
  assign stall_cycles = stall_q;
  assign load_use_events = lue_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: two controllers (3 bubbles / timeout 8, and 1 bubble / 4-bit counters) on shared stimulus
module tb_hazard_forward_ctrl;
  logic clk, rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_Rs1, id_ex_Rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic if_id_use_rs1, if_id_use_rs2, id_ex_MemRead, ex_mem_Regwrite, ex_mem_MemRead, ex_mem_MemWrite;
  logic mem_wb_Regwrite, dmem_ready, perf_clr;
  logic [1:0] fa3, fb3, fa1, fb1;
  logic sf3, bx3, fz3, mt3, sf1, bx1, fz1, mt1;
  logic [31:0] st3, lue3;
  logic [3:0] st1, lue1;
  logic [7:0] o3, o1;
  logic [15:0] sb [$];
  int n_cmp = 0;
  int n_bad = 0;
  // expected output vectors {forwardA, forwardB, stall_fd, bubble_ex, freeze, mem_timeout}
  localparam logic [7:0] Z = 8'b0000_0000, MT = 8'b0000_0001, BUB = 8'b0000_1100, FRZ = 8'b0000_1010;
  localparam logic [7:0] A10 = 8'b1000_0000, A01 = 8'b0100_0000, AB10 = 8'b1010_0000, B01 = 8'b0001_0000;
  assign o3 = {fa3, fb3, sf3, bx3, fz3, mt3};
  assign o1 = {fa1, fb1, sf1, bx1, fz1, mt1};

  hazard_forward_ctrl #(.REG_W(5), .LOAD_USE_STALLS(3), .MEM_TIMEOUT(8), .CNT_W(32)) u3 (
    .clk(clk), .rst(rst), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_Rs1(id_ex_Rs1), .id_ex_Rs2(id_ex_Rs2), .id_ex_rd(id_ex_rd), .id_ex_MemRead(id_ex_MemRead),
    .ex_mem_rd(ex_mem_rd), .ex_mem_Regwrite(ex_mem_Regwrite), .ex_mem_MemRead(ex_mem_MemRead),
    .ex_mem_MemWrite(ex_mem_MemWrite), .mem_wb_rd(mem_wb_rd), .mem_wb_Regwrite(mem_wb_Regwrite),
    .dmem_ready(dmem_ready), .perf_clr(perf_clr), .forwardA(fa3), .forwardB(fb3), .stall_fd(sf3),
    .bubble_ex(bx3), .freeze(fz3), .mem_timeout(mt3), .stall_cycles(st3), .load_use_events(lue3));

  hazard_forward_ctrl #(.REG_W(5), .LOAD_USE_STALLS(1), .MEM_TIMEOUT(255), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_Rs1(id_ex_Rs1), .id_ex_Rs2(id_ex_Rs2), .id_ex_rd(id_ex_rd), .id_ex_MemRead(id_ex_MemRead),
    .ex_mem_rd(ex_mem_rd), .ex_mem_Regwrite(ex_mem_Regwrite), .ex_mem_MemRead(ex_mem_MemRead),
    .ex_mem_MemWrite(ex_mem_MemWrite), .mem_wb_rd(mem_wb_rd), .mem_wb_Regwrite(mem_wb_Regwrite),
    .dmem_ready(dmem_ready), .perf_clr(perf_clr), .forwardA(fa1), .forwardB(fb1), .stall_fd(sf1),
    .bubble_ex(bx1), .freeze(fz1), .mem_timeout(mt1), .stall_cycles(st1), .load_use_events(lue1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic idle();
    {if_id_rs1, if_id_rs2, id_ex_Rs1, id_ex_Rs2, id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
    {if_id_use_rs1, if_id_use_rs2, id_ex_MemRead, ex_mem_Regwrite, ex_mem_MemRead, ex_mem_MemWrite, mem_wb_Regwrite} = '0;
    dmem_ready = 1'b1;
    perf_clr = 1'b0;
    rst = 1'b0;
  endtask

  task automatic lu_rs1();
    id_ex_MemRead = 1'b1;
    id_ex_rd = 5'd5;
    if_id_rs1 = 5'd5;
    if_id_use_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] ex [2];
    logic [15:0] e;
    ex = '{{Z, Z}, {Z, Z}};
    for (int i = 0; i < 2; i++) begin
      idle();
      if (i == 0) begin
        rst = 1'b1;
        lu_rs1();
        ex_mem_rd = 5'd3; ex_mem_Regwrite = 1'b1; ex_mem_MemWrite = 1'b1; dmem_ready = 1'b0; id_ex_Rs1 = 5'd3;
      end
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (o3 !== e[15:8]) begin n_bad++; $display("FAIL reset[%0d] u3 outputs got %b want %b", i, o3, e[15:8]); end
      if (o1 !== e[7:0]) begin n_bad++; $display("FAIL reset[%0d] u1 outputs got %b want %b", i, o1, e[7:0]); end
      @(posedge clk); #1;
    end
    n_cmp += 2;
    if ({st3, lue3} !== 64'd0) begin n_bad++; $display("FAIL reset u3 counters got %0d/%0d want 0/0", st3, lue3); end
    if ({st1, lue1} !== 8'd0) begin n_bad++; $display("FAIL reset u1 counters got %0d/%0d want 0/0", st1, lue1); end
  endtask

  task automatic test_forward();
    logic [15:0] ex [6];
    logic [15:0] e;
    ex = '{{A10, A10}, {A01, A01}, {AB10, AB10}, {Z, Z}, {A01, A01}, {B01, B01}};
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin ex_mem_rd = 5'd3; ex_mem_Regwrite = 1'b1; id_ex_Rs1 = 5'd3; id_ex_Rs2 = 5'd4; end
        1: begin mem_wb_rd = 5'd3; mem_wb_Regwrite = 1'b1; id_ex_Rs1 = 5'd3; end
        2: begin ex_mem_rd = 5'd3; ex_mem_Regwrite = 1'b1; mem_wb_rd = 5'd3; mem_wb_Regwrite = 1'b1;
                 id_ex_Rs1 = 5'd3; id_ex_Rs2 = 5'd3; end
        3: begin ex_mem_Regwrite = 1'b1; mem_wb_Regwrite = 1'b1; end
        4: begin ex_mem_rd = 5'd3; ex_mem_Regwrite = 1'b1; ex_mem_MemRead = 1'b1;
                 mem_wb_rd = 5'd3; mem_wb_Regwrite = 1'b1; id_ex_Rs1 = 5'd3; end
        default: begin ex_mem_rd = 5'd4; mem_wb_rd = 5'd7; mem_wb_Regwrite = 1'b1; id_ex_Rs1 = 5'd4; id_ex_Rs2 = 5'd7; end
      endcase
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (o3 !== e[15:8]) begin n_bad++; $display("FAIL forward[%0d] u3 outputs got %b want %b", i, o3, e[15:8]); end
      if (o1 !== e[7:0]) begin n_bad++; $display("FAIL forward[%0d] u1 outputs got %b want %b", i, o1, e[7:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [15:0] ex [7];
    logic [15:0] e;
    ex = '{{Z, Z}, {BUB, BUB}, {BUB, Z}, {BUB | A01, A01}, {Z, Z}, {Z, Z}, {Z, Z}};
    for (int i = 0; i < 7; i++) begin
      idle();
      case (i)
        0: perf_clr = 1'b1;
        1: lu_rs1();
        2: begin ex_mem_rd = 5'd5; ex_mem_Regwrite = 1'b1; ex_mem_MemRead = 1'b1; end
        3: begin mem_wb_rd = 5'd5; mem_wb_Regwrite = 1'b1; id_ex_Rs1 = 5'd5; end
        5: begin lu_rs1(); if_id_use_rs1 = 1'b0; end
        6: begin lu_rs1(); id_ex_rd = 5'd0; if_id_rs1 = 5'd0; end
        default: ;
      endcase
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (o3 !== e[15:8]) begin n_bad++; $display("FAIL load_use[%0d] u3 outputs got %b want %b", i, o3, e[15:8]); end
      if (o1 !== e[7:0]) begin n_bad++; $display("FAIL load_use[%0d] u1 outputs got %b want %b", i, o1, e[7:0]); end
      @(posedge clk); #1;
    end
    n_cmp += 2;
    if ({st3, lue3} !== {32'd3, 32'd1}) begin n_bad++; $display("FAIL load_use u3 stall/events got %0d/%0d want 3/1", st3, lue3); end
    if ({st1, lue1} !== {4'd1, 4'd1}) begin n_bad++; $display("FAIL load_use u1 stall/events got %0d/%0d want 1/1", st1, lue1); end
  endtask

  task automatic test_freeze();
    logic [15:0] ex [7];
    logic [15:0] e;
    ex = '{{Z, Z}, {FRZ, FRZ}, {FRZ, FRZ}, {FRZ, FRZ}, {FRZ, FRZ}, {Z, Z}, {Z, Z}};
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i == 0) perf_clr = 1'b1;
      if (i >= 1 && i <= 5) ex_mem_MemWrite = 1'b1;
      if (i >= 1 && i <= 4) dmem_ready = 1'b0;
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (o3 !== e[15:8]) begin n_bad++; $display("FAIL freeze[%0d] u3 outputs got %b want %b", i, o3, e[15:8]); end
      if (o1 !== e[7:0]) begin n_bad++; $display("FAIL freeze[%0d] u1 outputs got %b want %b", i, o1, e[7:0]); end
      @(posedge clk); #1;
    end
    n_cmp += 2;
    if (st3 !== 32'd4) begin n_bad++; $display("FAIL freeze u3 stall_cycles got %0d want 4", st3); end
    if (st1 !== 4'd4) begin n_bad++; $display("FAIL freeze u1 stall_cycles got %0d want 4", st1); end
  endtask

  task automatic test_lu_and_freeze();
    logic [15:0] ex [7];
    logic [15:0] e;
    ex = '{{Z, Z}, {FRZ, FRZ}, {Z, Z}, {BUB, BUB}, {BUB, Z}, {BUB, Z}, {Z, Z}};
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i == 0) perf_clr = 1'b1;
      if (i >= 1 && i <= 3) begin
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_use_rs2 = 1'b1;
      end
      if (i == 1 || i == 2) ex_mem_MemRead = 1'b1;
      if (i == 1) dmem_ready = 1'b0;
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (o3 !== e[15:8]) begin n_bad++; $display("FAIL lu_and_freeze[%0d] u3 outputs got %b want %b", i, o3, e[15:8]); end
      if (o1 !== e[7:0]) begin n_bad++; $display("FAIL lu_and_freeze[%0d] u1 outputs got %b want %b", i, o1, e[7:0]); end
      @(posedge clk); #1;
    end
    n_cmp += 2;
    if ({st3, lue3} !== {32'd4, 32'd1}) begin n_bad++; $display("FAIL lu_and_freeze u3 stall/events got %0d/%0d want 4/1", st3, lue3); end
    if ({st1, lue1} !== {4'd2, 4'd1}) begin n_bad++; $display("FAIL lu_and_freeze u1 stall/events got %0d/%0d want 2/1", st1, lue1); end
  endtask

  task automatic test_lu_freeze();
    logic [15:0] ex [7];
    logic [15:0] e;
    ex = '{{Z, Z}, {BUB, BUB}, {FRZ, FRZ}, {FRZ, FRZ}, {Z, Z}, {BUB, Z}, {Z, Z}};
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i == 0) perf_clr = 1'b1;
      if (i == 1) lu_rs1();
      if (i >= 2 && i <= 4) begin ex_mem_rd = 5'd5; ex_mem_Regwrite = 1'b1; ex_mem_MemRead = 1'b1; end
      if (i == 2 || i == 3) dmem_ready = 1'b0;
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (o3 !== e[15:8]) begin n_bad++; $display("FAIL lu_freeze[%0d] u3 outputs got %b want %b", i, o3, e[15:8]); end
      if (o1 !== e[7:0]) begin n_bad++; $display("FAIL lu_freeze[%0d] u1 outputs got %b want %b", i, o1, e[7:0]); end
      @(posedge clk); #1;
    end
    n_cmp += 2;
    if ({st3, lue3} !== {32'd4, 32'd1}) begin n_bad++; $display("FAIL lu_freeze u3 stall/events got %0d/%0d want 4/1", st3, lue3); end
    if ({st1, lue1} !== {4'd3, 4'd1}) begin n_bad++; $display("FAIL lu_freeze u1 stall/events got %0d/%0d want 3/1", st1, lue1); end
  endtask

  task automatic test_timeout();
    logic [15:0] ex [12];
    logic [15:0] e;
    ex = '{{Z, Z}, {FRZ, FRZ}, {FRZ, FRZ}, {FRZ, FRZ}, {FRZ, FRZ}, {FRZ, FRZ}, {FRZ, FRZ},
           {FRZ, FRZ}, {FRZ, FRZ}, {Z, FRZ}, {MT, Z}, {MT, Z}};
    for (int i = 0; i < 12; i++) begin
      idle();
      if (i == 0) perf_clr = 1'b1;
      if (i >= 1 && i <= 9) begin ex_mem_MemRead = 1'b1; dmem_ready = 1'b0; end
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (o3 !== e[15:8]) begin n_bad++; $display("FAIL timeout[%0d] u3 outputs got %b want %b", i, o3, e[15:8]); end
      if (o1 !== e[7:0]) begin n_bad++; $display("FAIL timeout[%0d] u1 outputs got %b want %b", i, o1, e[7:0]); end
      @(posedge clk); #1;
    end
    n_cmp += 2;
    if (st3 !== 32'd8) begin n_bad++; $display("FAIL timeout u3 stall_cycles got %0d want 8", st3); end
    if (st1 !== 4'd9) begin n_bad++; $display("FAIL timeout u1 stall_cycles got %0d want 9", st1); end
  endtask

  task automatic test_saturation();
    idle();
    perf_clr = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      idle();
      lu_rs1();
      @(posedge clk); #1;
    end
    n_cmp += 2;
    if ({st1, lue1} !== {4'd15, 4'd15}) begin n_bad++; $display("FAIL saturate u1 stall/events got %0d/%0d want 15/15", st1, lue1); end
    if ({st3, lue3} !== {32'd18, 32'd6}) begin n_bad++; $display("FAIL saturate u3 stall/events got %0d/%0d want 18/6", st3, lue3); end
    perf_clr = 1'b1;
    @(posedge clk); #1;
    idle();
    n_cmp += 2;
    if ({st1, lue1} !== 8'd0) begin n_bad++; $display("FAIL clr_wins u1 stall/events got %0d/%0d want 0/0", st1, lue1); end
    if ({st3, lue3} !== 64'd0) begin n_bad++; $display("FAIL clr_wins u3 stall/events got %0d/%0d want 0/0", st3, lue3); end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ex [7];
    logic [15:0] e;
    ex = '{{BUB | MT, BUB}, {Z, Z}, {A10, A10}, {FRZ, FRZ}, {FRZ, FRZ}, {Z, Z}, {B01, B01}};
    for (int i = 0; i < 7; i++) begin
      idle();
      case (i)
        0: lu_rs1();
        1: begin rst = 1'b1; lu_rs1(); ex_mem_rd = 5'd3; ex_mem_Regwrite = 1'b1; id_ex_Rs1 = 5'd3; end
        2: begin ex_mem_rd = 5'd3; ex_mem_Regwrite = 1'b1; id_ex_Rs1 = 5'd3; end
        3, 4: begin ex_mem_MemWrite = 1'b1; dmem_ready = 1'b0; end
        5: begin rst = 1'b1; ex_mem_MemWrite = 1'b1; dmem_ready = 1'b0; end
        default: begin mem_wb_rd = 5'd9; mem_wb_Regwrite = 1'b1; id_ex_Rs2 = 5'd9; end
      endcase
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (o3 !== e[15:8]) begin n_bad++; $display("FAIL reset_mid[%0d] u3 outputs got %b want %b", i, o3, e[15:8]); end
      if (o1 !== e[7:0]) begin n_bad++; $display("FAIL reset_mid[%0d] u1 outputs got %b want %b", i, o1, e[7:0]); end
      @(posedge clk); #1;
    end
    n_cmp += 2;
    if ({st3, lue3} !== 64'd0) begin n_bad++; $display("FAIL reset_mid u3 counters got %0d/%0d want 0/0", st3, lue3); end
    if ({st1, lue1} !== 8'd0) begin n_bad++; $display("FAIL reset_mid u1 counters got %0d/%0d want 0/0", st1, lue1); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_forward();
    test_load_use();
    test_freeze();
    test_lu_and_freeze();
    test_lu_freeze();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
